// File: rtl/wb_burst_mem_responder.sv
// Wishbone B3 responder with internal word memory: classic cycles and linear/wrap4/8/16 bursts. Optional WB_RESP_ERR_EN.
// Latency: first ack WAIT_STATES+1 cycles after strobe, then one beat per cycle while the master follows the predicted address.
// Backpressure: stb low drops ack and holds the burst address; ack returns the cycle after stb comes back.
module wb_burst_mem_responder #(
  parameter int unsigned MEM_WORDS     = 4096,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned WAIT_STATES   = 0,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CLASSIC, S_BURST} state_t;

  state_t        state, state_d;
  logic          ack_q, ack_d;
  logic [29:0]   pa, pa_d, pa_nxt, rd_wa;
  logic [3:0]    cnt, cnt_d;
  logic          req, resp, start, rd_en;
  logic [31:0]   cur_off, rd_off;
  logic [AW-1:0] cur_idx, rd_idx;
  logic          cur_oor, rd_oor;
  logic          unused_sig;
  logic [31:0]   mem [MEM_WORDS];

  assign cur_off = {wb_adr_i[31:2], 2'b00} - BASE_ADDR;
  assign rd_off  = {rd_wa, 2'b00} - BASE_ADDR;
  assign cur_idx = cur_off[AW+1:2];
  assign rd_idx  = rd_off[AW+1:2];
  assign cur_oor = |cur_off[31:AW+2];
  assign rd_oor  = |rd_off[31:AW+2];

  assign req  = wb_cyc_i & wb_stb_i;
  // In a burst the registered ack only counts while the master sits on the predicted address.
  assign resp = ack_q & req & ((state != S_BURST) | (wb_adr_i[31:2] == pa));

`ifdef WB_RESP_ERR_EN
  assign wb_ack_o   = resp & ~cur_oor;
  assign wb_err_o   = resp & cur_oor;
  assign unused_sig = ^{wb_adr_i[1:0], cur_off[1:0], rd_off[1:0]};
`else
  assign wb_ack_o   = resp;
  assign wb_err_o   = 1'b0;
  assign unused_sig = ^{wb_adr_i[1:0], cur_off[1:0], rd_off[1:0], cur_oor, rd_oor};
`endif
  assign wb_rty_o = 1'b0;

  always_comb begin
    case (wb_bte_i)
      2'b01:   pa_nxt = {pa[29:2], pa[1:0] + 2'd1};
      2'b10:   pa_nxt = {pa[29:3], pa[2:0] + 3'd1};
      2'b11:   pa_nxt = {pa[29:4], pa[3:0] + 4'd1};
      default: pa_nxt = pa + 30'd1;
    endcase
  end

  always_comb begin
    state_d = state;
    ack_d   = 1'b0;
    pa_d    = pa;
    cnt_d   = cnt;
    rd_en   = 1'b0;
    rd_wa   = wb_adr_i[31:2];
    start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && !ack_q) begin
          if (WAIT_STATES > 0) begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = S_WAIT;
          end else begin
            start = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!req)              state_d = S_IDLE;
        else if (cnt == 4'd0)  start   = 1'b1;
        else                   cnt_d   = cnt - 4'd1;
      end
      S_CLASSIC: state_d = S_IDLE;
      S_BURST: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (resp) begin
          if (wb_cti_i == 3'b111 || wb_err_o) begin
            state_d = S_IDLE;
          end else begin
            // Prefetch the next predicted word so the following beat can ack immediately.
            ack_d = 1'b1;
            pa_d  = pa_nxt;
            rd_en = 1'b1;
            rd_wa = pa_nxt;
          end
        end else if (wb_stb_i) begin
          ack_d = 1'b1;
          pa_d  = wb_adr_i[31:2];
          rd_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      ack_d   = 1'b1;
      pa_d    = wb_adr_i[31:2];
      rd_en   = 1'b1;
      state_d = (wb_cti_i == 3'b010) ? S_BURST : S_CLASSIC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ack_q <= 1'b0;
      pa    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      ack_q <= ack_d;
      pa    <= pa_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_dat_o <= '0;
    end else if (rd_en) begin
`ifdef WB_RESP_ERR_EN
      wb_dat_o <= rd_oor ? 32'd0 : mem[rd_idx];
`else
      wb_dat_o <= mem[rd_idx];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wb_ack_o && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[cur_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_wb_burst_mem_responder.sv
// Directed bench for wb_burst_mem_responder: two instances (0 and 3 wait states) share one master;
// a transaction-level memory model predicts ack/err/data, checked every falling edge.
module tb_wb_burst_mem_responder;
  localparam int MW = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cyc, stb, we, use3;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat0, dat3, dat;
  logic        ack0, ack3, err0, err3, rty0, rty3, ack, err, rty;

  assign ack = use3 ? ack3 : ack0;
  assign err = use3 ? err3 : err0;
  assign rty = use3 ? rty3 : rty0;
  assign dat = use3 ? dat3 : dat0;

  wb_burst_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc & ~use3), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0));

  wb_burst_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc & use3), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3));

  logic [31:0] mdl [2][MW];
  logic        chk_en, exp_ack, exp_err, exp_rd;
  logic [31:0] exp_dat, last_dat;
  logic [31:0] badr [16];
  logic [31:0] bdat [16];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return ((a - 32'h0) >> 2) % MW;
  endfunction

  function automatic logic [31:0] wd(input logic [31:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // Next burst address: wrap blocks are 16/32/64 bytes, linear just adds one word.
  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] bt);
    logic [31:0] m;
    m = (bt == 2'b01) ? 32'hF : (bt == 2'b10) ? 32'h1F : 32'h3F;
    if (bt == 2'b00) return a + 32'd4;
    return (a & ~m) | ((a + 32'd4) & m);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("err", 32'(err), 32'(exp_err));
      chk("rty", 32'(rty), 32'd0);
      if (exp_ack && exp_rd) chk("rdata", dat, exp_dat);
      if (exp_err) chk("err_data", dat, 32'd0);
    end
  end

  task automatic classic(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int ws;
    bit e;
    int unsigned ix;
    ws = use3 ? 3 : 0;
    e  = 1'b0;
`ifdef WB_RESP_ERR_EN
    e  = (a >= 32'(4 * MW));
`endif
    ix = widx(a);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d; cti = 3'b000; bte = 2'b00;
    exp_ack = 0; exp_err = 0;
    repeat (ws) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    exp_ack = !e; exp_err = e; exp_rd = !w && !e; exp_dat = e ? 32'd0 : mdl[use3][ix];
    @(negedge clk);
    last_dat = dat;
    @(posedge clk); #1;
    if (w && !e) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[use3][ix][8*b +: 8] = d[8*b +: 8];
    end
    cyc = 0; stb = 0; we = 0; exp_ack = 0; exp_err = 0;
  endtask

  task automatic burst(input bit w, input logic [1:0] bt, input int n,
                       input int stall_after, input int stall_len, input int drop_after);
    int ws, lat, k;
    logic [31:0] pred;
    int unsigned ix;
    ws = use3 ? 3 : 0;
    lat = ws + 1; k = 0; pred = badr[0];
    while (k < n) begin
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = w; sel = 4'hF; bte = bt; adr = badr[k]; wdat = wd(badr[k]);
      cti = (k == n - 1) ? 3'b111 : 3'b010;
      exp_err = 0;
      if (lat == 0 && badr[k] != pred) lat = 1;
      if (lat > 0) begin
        exp_ack = 0; lat--; pred = badr[k];
      end else begin
        ix = widx(badr[k]);
        exp_ack = 1; exp_rd = !w; exp_dat = mdl[use3][ix];
        @(negedge clk);
        bdat[k] = dat;
        if (w) mdl[use3][ix] = wd(badr[k]);
        pred = nxt(badr[k], bt);
        k++;
        if (k == drop_after) begin
          @(posedge clk); #1;
          cyc = 0; stb = 0; we = 0; exp_ack = 0;
          repeat (3) @(posedge clk);
          #1;
          return;
        end
        if (k == stall_after) begin
          repeat (stall_len) begin @(posedge clk); #1; stb = 0; exp_ack = 0; end
          lat = 1;
        end
      end
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0; cti = 3'b000; exp_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; cti = 0; bte = 0; use3 = 0;
    chk_en = 0; exp_ack = 0; exp_err = 0; exp_rd = 0; exp_dat = 0; last_dat = 0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < MW; i++) mdl[d][i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_dat0", dat0, 32'd0);
    chk("rst_ack3", 32'(ack3), 32'd0);
    chk("rst_dat3", dat3, 32'd0);
    @(negedge clk);
    rst = 0;
    chk_en = 1;

    for (int i = 0; i < 20; i++) classic(1, 32'(i * 4), 4'hF, 32'hA5A50000 + 32'(i));

    classic(1, 32'h10, 4'hF, 32'hDEADBEEF);
    classic(0, 32'h10, 4'hF, 32'h0);
    chk("lit_rd_word4", last_dat, 32'hDEADBEEF);

    classic(1, 32'h08, 4'hF, 32'h11223344);
    classic(1, 32'h08, 4'b0101, 32'hAABBCCDD);
    classic(0, 32'h08, 4'hF, 32'h0);
    chk("lit_sel0101", last_dat, 32'h11BB33DD);

    classic(1, 32'h14, 4'b0000, 32'hFFFFFFFF);
    classic(0, 32'h14, 4'hF, 32'h0);
    chk("lit_sel0000", last_dat, 32'hA5A50005);

    badr[0] = 32'h0C; badr[1] = 32'h00; badr[2] = 32'h04; badr[3] = 32'h08;
    burst(0, 2'b01, 4, -1, 0, -1);
    chk("lit_wrap4_b0", bdat[0], 32'hA5A50003);
    chk("lit_wrap4_b3", bdat[3], 32'h11BB33DD);

    badr[0] = 32'h20; badr[1] = 32'h24; badr[2] = 32'h40; badr[3] = 32'h44;
    burst(0, 2'b00, 4, -1, 0, -1);
    chk("lit_jump_b2", bdat[2], 32'hA5A50010);

    for (int i = 0; i < 4; i++) badr[i] = 32'h100 + 32'(4 * i);
    burst(1, 2'b00, 4, 2, 2, -1);
    for (int i = 0; i < 4; i++) classic(0, 32'h100 + 32'(4 * i), 4'hF, 32'h0);
    chk("lit_wburst_last", last_dat, 32'hC0DE010C);

    classic(1, 32'h4000, 4'hF, 32'h12345678);
    classic(0, 32'h0, 4'hF, 32'h0);
`ifdef WB_RESP_ERR_EN
    chk("lit_oor_unchanged", last_dat, 32'hA5A50000);
`else
    chk("lit_alias_word0", last_dat, 32'h12345678);
`endif

    use3 = 1;
    classic(1, 32'h14, 4'hF, 32'h5555AAAA);
    classic(0, 32'h14, 4'hF, 32'h0);
    chk("lit_ws3_rd", last_dat, 32'h5555AAAA);
    for (int i = 0; i < 4; i++) classic(1, 32'h80 + 32'(4 * i), 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) badr[i] = 32'h80 + 32'(4 * i);
    burst(1, 2'b00, 8, -1, 0, 3);
    for (int i = 0; i < 4; i++) begin
      classic(0, 32'h80 + 32'(4 * i), 4'hF, 32'h0);
      bdat[i] = last_dat;
    end
    chk("lit_drop_b2", bdat[2], 32'hC0DE0088);
    chk("lit_drop_b3", bdat[3], 32'h0);
    use3 = 0;

    chk_en = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h0; cti = 3'b010; bte = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    adr = 32'h4;
    @(negedge clk);
    chk("pre_rst_ack", 32'(ack0), 32'd1);
    #1 rst = 1;
    #1;
    chk("mid_rst_ack", 32'(ack0), 32'd0);
    chk("mid_rst_err", 32'(err0), 32'd0);
    chk("mid_rst_dat", dat0, 32'd0);
    cyc = 0; stb = 0; cti = 3'b000;
    @(negedge clk);
    rst = 0;
    exp_ack = 0; exp_err = 0;
    chk_en = 1;
    classic(0, 32'h10, 4'hF, 32'h0);
    chk("lit_after_rst", last_dat, 32'hDEADBEEF);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
